// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the pipeline debug controller.
package debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_END  = 8'h45;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD_CNT   = 4'd1,
        LOAD_BYTE  = 4'd2,
        LOAD_WR    = 4'd3,
        RUN_RST    = 4'd4,
        RUN        = 4'd5,
        STEP_RST   = 4'd6,
        STEP_WAIT  = 4'd7,
        STEP_CLK   = 4'd8,
        DUMP_ADDR  = 4'd9,
        DUMP_LATCH = 4'd10,
        DUMP_SEND  = 4'd11,
        DUMP_WAIT  = 4'd12
    } state_t;

endpackage

// File: rtl/dump_serializer.sv
// Splits a loaded word into bytes, MSB first, over the UART TX start/done handshake.
// Latency: first tx_start one cycle after load; o_done is combinational with the last tx_done.
// Backpressure: each byte is held on o_tx_data until TX acknowledges it with i_tx_done.
module dump_serializer
    import debug_pkg::*;
#(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic [NB_WORD-1:0] i_word,
    input  logic               i_tx_done,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_done
);

    localparam int NB_CNT = $clog2(BYTES_PER_WORD);

    logic [NB_WORD-1:0] shreg;
    logic [NB_CNT-1:0]  byte_cnt;
    logic               waiting;
    logic               byte_acked;

    // A done coinciding with the start pulse belongs to no byte of ours.
    assign byte_acked = waiting && !o_tx_start && i_tx_done;
    assign o_done     = byte_acked && (byte_cnt == NB_CNT'(BYTES_PER_WORD - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shreg      <= '0;
            byte_cnt   <= '0;
            waiting    <= 1'b0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            if (i_load) begin
                o_tx_data  <= i_word[NB_WORD-1 -: NB_BYTE];
                shreg      <= i_word << NB_BYTE;
                byte_cnt   <= '0;
                waiting    <= 1'b1;
                o_tx_start <= 1'b1;
            end else if (byte_acked) begin
                if (o_done) begin
                    waiting <= 1'b0;
                end else begin
                    byte_cnt   <= byte_cnt + NB_CNT'(1);
                    o_tx_data  <= shreg[NB_WORD-1 -: NB_BYTE];
                    shreg      <= shreg << NB_BYTE;
                    o_tx_start <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/debug_unit.sv
// UART debug controller: loads imem, runs/steps the pipeline, dumps regs and dmem to host.
// Latency: commands act the cycle after i_rx_done; halt stops clk_en combinationally.
// Backpressure: dump bytes wait on i_tx_done; RX bytes outside IDLE/LOAD/STEP_WAIT are dropped.
module debug_unit
    import debug_pkg::*;
#(
    parameter int NB_REG      = 32,
    parameter int NB_DATA     = 8,
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 32,
    parameter int INST_WORDS  = 128
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_halt,
    input  logic [NB_REG-1:0]  i_dunit_reg,
    input  logic [NB_REG-1:0]  i_dunit_mem_data,
    output logic               o_dunit_clk_en,
    output logic               o_dunit_reset_pc,
    output logic               o_dunit_w_mem,
    output logic [NB_REG-1:0]  o_dunit_addr,
    output logic [NB_REG-1:0]  o_dunit_data_if,
    output logic [3:0]         o_state
);

    localparam int N_DUMP = N_REGS + N_MEM_WORDS;
    localparam int NB_IDX = $clog2(N_DUMP + 1);
    localparam int NB_CNT = $clog2(BYTES_PER_WORD);

    state_t                     state;
    logic [NB_DATA-1:0]         load_n;
    logic [NB_DATA-1:0]         word_idx;
    logic [NB_CNT-1:0]          byte_cnt;
    logic [NB_REG-NB_DATA-1:0]  asm_word;
    logic [NB_IDX-1:0]          dump_idx;
    logic                       step_mode;

    logic [NB_REG-1:0]          asm_next;
    logic [NB_REG-1:0]          load_addr;
    logic [NB_REG-1:0]          next_dump_addr;
    logic [NB_REG-1:0]          dump_word;
    logic                       last_dump;
    logic                       ser_done;

    // Registers are addressed by index, data memory by byte address.
    function automatic logic [NB_REG-1:0] dump_addr(input logic [NB_IDX-1:0] idx);
        if (idx < NB_IDX'(N_REGS))
            return NB_REG'(idx);
        return NB_REG'(idx - NB_IDX'(N_REGS)) * NB_REG'(BYTES_PER_WORD);
    endfunction

    assign asm_next       = {asm_word, i_rx_data};
    assign load_addr      = (NB_REG'(word_idx) % NB_REG'(INST_WORDS)) * NB_REG'(BYTES_PER_WORD);
    assign next_dump_addr = dump_addr(dump_idx + NB_IDX'(1));
    assign dump_word      = (dump_idx < NB_IDX'(N_REGS)) ? i_dunit_reg : i_dunit_mem_data;
    assign last_dump      = (dump_idx == NB_IDX'(N_DUMP - 1));

    // Gate is combinational so the cycle in which halt rises is not clocked.
    assign o_dunit_clk_en = ((state == RUN) && !i_halt) || (state == STEP_CLK);
    assign o_state        = state;

    dump_serializer #(
        .NB_WORD (NB_REG),
        .NB_BYTE (NB_DATA)
    ) u_dump_serializer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (state == DUMP_LATCH),
        .i_word     (dump_word),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_done     (ser_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state            <= IDLE;
            load_n           <= '0;
            word_idx         <= '0;
            byte_cnt         <= '0;
            asm_word         <= '0;
            dump_idx         <= '0;
            step_mode        <= 1'b0;
            o_dunit_reset_pc <= 1'b0;
            o_dunit_w_mem    <= 1'b0;
            o_dunit_addr     <= '0;
            o_dunit_data_if  <= '0;
        end else begin
            o_dunit_reset_pc <= 1'b0;
            o_dunit_w_mem    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_done) begin
                        case (i_rx_data)
                            CMD_LOAD: state <= LOAD_CNT;
                            CMD_CONT: begin
                                state            <= RUN_RST;
                                o_dunit_reset_pc <= 1'b1;
                                step_mode        <= 1'b0;
                            end
                            CMD_STEP: begin
                                state            <= STEP_RST;
                                o_dunit_reset_pc <= 1'b1;
                                step_mode        <= 1'b1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                LOAD_CNT: begin
                    if (i_rx_done) begin
                        load_n   <= i_rx_data;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        state    <= (i_rx_data == '0) ? IDLE : LOAD_BYTE;
                    end
                end
                LOAD_BYTE: begin
                    if (i_rx_done) begin
                        asm_word <= asm_next[NB_REG-NB_DATA-1:0];
                        if (byte_cnt == NB_CNT'(BYTES_PER_WORD - 1)) begin
                            o_dunit_w_mem   <= 1'b1;
                            o_dunit_addr    <= load_addr;
                            o_dunit_data_if <= asm_next;
                            byte_cnt        <= '0;
                            state           <= LOAD_WR;
                        end else begin
                            byte_cnt <= byte_cnt + NB_CNT'(1);
                        end
                    end
                end
                LOAD_WR: begin
                    word_idx <= word_idx + NB_DATA'(1);
                    state    <= (word_idx + NB_DATA'(1) == load_n) ? IDLE : LOAD_BYTE;
                end
                RUN_RST: state <= RUN;
                RUN: begin
                    if (i_halt) begin
                        dump_idx     <= '0;
                        o_dunit_addr <= '0;
                        state        <= DUMP_ADDR;
                    end
                end
                STEP_RST: state <= STEP_WAIT;
                STEP_WAIT: begin
                    if (i_rx_done) begin
                        if (i_rx_data == CMD_NEXT)
                            state <= STEP_CLK;
                        else if (i_rx_data == CMD_END)
                            state <= IDLE;
                    end
                end
                STEP_CLK: begin
                    dump_idx     <= '0;
                    o_dunit_addr <= '0;
                    state        <= DUMP_ADDR;
                end
                DUMP_ADDR:  state <= DUMP_LATCH;
                DUMP_LATCH: state <= DUMP_SEND;
                DUMP_SEND:  state <= DUMP_WAIT;
                DUMP_WAIT: begin
                    if (ser_done) begin
                        if (last_dump) begin
                            state <= (step_mode && !i_halt) ? STEP_WAIT : IDLE;
                        end else begin
                            dump_idx     <= dump_idx + NB_IDX'(1);
                            o_dunit_addr <= next_dump_addr;
                            state        <= DUMP_ADDR;
                        end
                    end else if (i_tx_done) begin
                        state <= DUMP_SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/debug_unit.md
# debug_unit

UART-facing debug controller sitting directly upstream of the MIPS `pipeline` top. It takes a program from the host and writes it into instruction memory. It runs the pipeline either continuously until halt or one clock at a time. After each run or step it serialises the register file and the first data-memory words back to the host. It drives every `i_dunit_*` input of the pipeline and consumes `o_dunit_reg`, `o_dunit_mem_data` and `o_halt`.

## Interface
- `NB_REG`, 32, pipeline data/address width
- `NB_DATA`, 8, UART byte width
- `N_REGS`, 32, registers dumped
- `N_MEM_WORDS`, 32, data-memory words dumped (byte addresses 0..4·N−4)
- `INST_WORDS`, 128, instruction-memory depth in words

Ports:
- `i_clk`  in  1  single clock
- `i_reset`  in  1  reset; synchronous, active-high
- `i_rx_data`  in  8  byte from UART RX
- `i_rx_done`  in  1  one-cycle pulse, `i_rx_data` valid
- `i_tx_done`  in  1  one-cycle pulse, TX finished current byte
- `o_tx_data`  out  8  byte to UART TX
- `o_tx_start`  out  1  one-cycle pulse, start sending `o_tx_data`
- `i_halt`  in  1  pipeline halt reached
- `i_dunit_reg`  in  32  register-file read data for `o_dunit_addr[4:0]`
- `i_dunit_mem_data`  in  32  data-memory word at `o_dunit_addr`
- `o_dunit_clk_en`  out  1  pipeline clock enable
- `o_dunit_reset_pc`  out  1  one-cycle PC reset
- `o_dunit_w_mem`  out  1  instruction-memory write strobe
- `o_dunit_addr`  out  32  byte address (imem/dmem) or register index
- `o_dunit_data_if`  out  32  instruction word to write
- `o_state`  out  4  current state encoding, for LEDs

## Operation
- **Reset values:** all outputs 0 and state IDLE. `i_reset` in any state aborts the operation in the next cycle; the partial word and counters are discarded.
- **Commands.** In IDLE, one byte on `i_rx_done` selects the command:
  - 'L' (0x4C) selects load.
  - 'C' (0x43) selects continuous run.
  - 'S' (0x53) selects step mode.
  - Any other byte is ignored.
  - RX bytes are also ignored in RUN and DUMP.
- **LOAD.**
  - The next byte is the count N. N=0 returns to IDLE.
  - Then 4·N bytes follow, MSB first, assembled into a 32-bit word.
  - On the 4th byte of word k: `o_dunit_w_mem`=1 for exactly one cycle, with `o_dunit_addr`=4·(k mod `INST_WORDS`) and `o_dunit_data_if`=word. Words beyond `INST_WORDS` wrap.
  - After word N−1 the block goes to IDLE. `o_dunit_clk_en` stays 0 throughout.
- **RUN ('C').**
  - One cycle of `o_dunit_reset_pc`=1.
  - Then `o_dunit_clk_en` = (state==RUN) && !`i_halt`; the gate is combinational, so no extra pipeline cycle occurs after halt.
  - When `i_halt`=1, go to DUMP, then IDLE.
- **STEP ('S').**
  - One cycle of `o_dunit_reset_pc`, then STEP_WAIT.
  - 'N' (0x4E) gives exactly one cycle of `o_dunit_clk_en`=1, then DUMP.
  - After the dump, return to STEP_WAIT, or to IDLE if `i_halt`=1.
  - 'E' (0x45) in STEP_WAIT goes to IDLE. Other bytes are ignored.
- **DUMP.** `o_dunit_clk_en`=0 throughout.
  - Per word: ADDR cycle (drive `o_dunit_addr`), LATCH cycle (capture the input word).
  - Then 4 bytes, MSB first. Each byte is SEND (`o_tx_start` pulse, `o_tx_data` held until `i_tx_done`) followed by WAIT (for `i_tx_done`).
  - Registers 0..`N_REGS`−1 are sent first, from `i_dunit_reg` with `o_dunit_addr`=index.
  - Then memory words j=0..`N_MEM_WORDS`−1, from `i_dunit_mem_data` with `o_dunit_addr`=4·j.
  - Total 4·(`N_REGS`+`N_MEM_WORDS`) bytes (256 at defaults).
- **States:** IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN_RST, RUN, STEP_RST, STEP_WAIT, STEP_CLK, DUMP_ADDR, DUMP_LATCH, DUMP_SEND, DUMP_WAIT. `o_state` carries the enum value.
- **Simultaneous events:** an `i_tx_done` that arrives in the same cycle as SEND is not expected; the WAIT state only samples it after SEND.

## Timing
- `i_rx_done` of a command byte in cycle t → state change at t+1.
- 'C' at t: `o_dunit_reset_pc`=1 at t+1; `o_dunit_clk_en`=1 from t+2.
- 4th load byte at t: `o_dunit_w_mem`=1 at t+1 only.
- `i_halt` rising at t in RUN: `o_dunit_clk_en`=0 at t; DUMP_ADDR at t+1; first `o_tx_start` at t+3.
- 'N' at t: `o_dunit_clk_en`=1 at t+1 only; DUMP_ADDR at t+2.
- Read data is sampled one cycle after the address is driven; register file and data-memory reads must settle within one cycle.

## Structure
- Package `debug_pkg` holds:
  - command byte constants ('L','C','S','N','E')
  - state enum (4-bit)
  - byte-per-word constant 4
- One sub-module, `dump_serializer`: loads a 32-bit word, emits 4 bytes MSB first with the `o_tx_start`/`i_tx_done` handshake, and pulses done. The FSM, load assembler and counters stay in `debug_unit`.

## Test plan
- **Load:** 'L', 0x02, bytes 20 01 00 05 8C 02 00 00 → `o_dunit_w_mem` pulses twice, (addr 0, 0x20010005) then (addr 4, 0x8C020000); `o_dunit_clk_en` never 1.
- **Continuous run:** 'C', with `i_halt` raised after 10 enable cycles → reset_pc 1 cycle, exactly 10 `o_dunit_clk_en` cycles, then 256 `o_tx_start` pulses with reg 1 = 0x00000005 sent as 00 00 00 05; back to IDLE.
- **Step:** 'S', 'N', 'N', 'E' → each 'N` gives exactly one clk_en cycle followed by a full 256-byte dump; 'E' returns to IDLE with no further TX.
- **Step into halt:** 'S', then 'N' with `i_halt`=1 after the step → dump, then IDLE (not STEP_WAIT).
- **Reset mid-operation:** `i_reset` during the 2nd load byte and again mid-dump → all outputs 0 next cycle and IDLE; a subsequent 'L' load restarts at addr 0.
- **Ignored bytes:** 'X' in IDLE and bytes received during RUN or DUMP → no state change and no output activity.
